// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one host memory port, one transaction in flight
//   Requester side: req_valid/req_write/req_addr/req_wdata in, req_ready acceptance pulse out,
//                   rsp_valid/rsp_data/rsp_err completion to the owning requester.
//   Memory side:    mem_address/mem_write_data/mem_*_request_valid out,
//                   mem_data_valid/mem_write_done/mem_read_data in.
//   Status:         busy, sticky err_timeout and err_unsolicited.
module mem_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      buffer_addr_valid,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][511:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [511:0]              rsp_data,
  output logic                      rsp_err,
  output logic [31:0]               mem_address,
  output logic [511:0]              mem_write_data,
  output logic                      mem_read_request_valid,
  output logic                      mem_write_request_valid,
  input  logic                      mem_data_valid,
  input  logic                      mem_write_done,
  input  logic [511:0]              mem_read_data,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_unsolicited
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW:0]   NR   = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr, r_owner, w_off, w_pick, w_next_ptr;
  logic [IW:0]     w_sum;
  logic [NUM_REQ-1:0] w_rot;
  logic [CW-1:0]   r_cnt;
  logic            r_write, w_done, w_wrong, w_stray;
  // Rotate requests so bit 0 is the rr_ptr requester; the lowest set bit is the winner.
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (w_rot[i]) w_off = IW'(i);
  end
  assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_pick     = (w_sum >= NR) ? IW'(w_sum - NR) : w_sum[IW-1:0];
  assign w_next_ptr = (r_owner == LAST) ? '0 : r_owner + IW'(1);
  assign w_done     = r_write ? mem_write_done : mem_data_valid;
  assign w_wrong    = r_write ? mem_data_valid : mem_write_done;
  assign w_stray    = (r_state != S_WAIT) && (mem_data_valid || mem_write_done);
  assign busy       = r_state != S_IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state                 <= S_IDLE;
      r_rr_ptr                <= '0;
      r_owner                 <= '0;
      r_write                 <= 1'b0;
      r_cnt                   <= '0;
      req_ready               <= '0;
      rsp_valid               <= '0;
      rsp_data                <= '0;
      rsp_err                 <= 1'b0;
      mem_address             <= '0;
      mem_write_data          <= '0;
      mem_read_request_valid  <= 1'b0;
      mem_write_request_valid <= 1'b0;
      err_timeout             <= 1'b0;
      err_unsolicited         <= 1'b0;
    end else begin
      req_ready               <= '0;
      rsp_valid               <= '0;
      rsp_err                 <= 1'b0;
      mem_read_request_valid  <= 1'b0;
      mem_write_request_valid <= 1'b0;
      if (w_stray || (r_state == S_WAIT && w_wrong)) err_unsolicited <= 1'b1;
      case (r_state)
        S_IDLE: if (buffer_addr_valid && |req_valid) begin
          req_ready      <= NUM_REQ'(1) << w_pick;
          r_owner        <= w_pick;
          r_write        <= req_write[w_pick];
          mem_address    <= req_addr[w_pick];
          mem_write_data <= req_wdata[w_pick];
          r_state        <= S_ISSUE;
        end
        S_ISSUE: begin
          mem_read_request_valid  <= !r_write;
          mem_write_request_valid <= r_write;
          r_cnt                   <= '0;
          r_state                 <= S_WAIT;
        end
        default: begin
          // A completion arriving on the expiry cycle takes priority over the timeout.
          if (w_done || r_cnt == TMAX) begin
            rsp_valid <= NUM_REQ'(1) << r_owner;
            rsp_err   <= !w_done;
            if (!w_done) err_timeout <= 1'b1;
            if (w_done && !r_write) rsp_data <= mem_read_data;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= S_IDLE;
          end else if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, bav = 1'b0;
  logic [N-1:0] req_valid = '0, req_write = '0;
  logic [N-1:0][31:0]  req_addr  = '0;
  logic [N-1:0][511:0] req_wdata = '0;
  logic dv = 1'b0, wd = 1'b0;
  logic [511:0] rdata = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [511:0] rsp_data, mem_write_data;
  logic [31:0]  mem_address;
  logic rsp_err, rd, wr, busy, err_to, err_un;
  int checks = 0, failures = 0;
  int m_ptr, m_owner, m_age;
  bit m_active, m_write;
  logic [N-1:0] e_ready, e_rsp_valid;
  logic e_rsp_err, e_rd, e_wr, e_err_to, e_err_un;
  logic [511:0] e_rsp_data, e_wdata;
  logic [31:0]  e_addr;

  mem_port_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .buffer_addr_valid(bav),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_request_valid(rd), .mem_write_request_valid(wr),
    .mem_data_valid(dv), .mem_write_done(wd), .mem_read_data(rdata),
    .busy(busy), .err_timeout(err_to), .err_unsolicited(err_un)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] r512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_owner = 0; m_age = 0; m_active = 0; m_write = 0;
    e_ready = '0; e_rsp_valid = '0; e_rsp_err = 0; e_rd = 0; e_wr = 0;
    e_err_to = 0; e_err_un = 0; e_rsp_data = '0; e_wdata = '0; e_addr = '0;
  endtask

  // m_age counts cycles since acceptance: 0 = acceptance cycle, 1 = memory request cycle,
  // and the memory has until age TO to answer before the timeout completion.
  task automatic m_step();
    int idx;
    bit done;
    e_ready = '0; e_rsp_valid = '0; e_rsp_err = 0; e_rd = 0; e_wr = 0;
    if (!m_active || m_age == 0) begin
      if (dv || wd) e_err_un = 1;
      if (m_active) begin
        e_rd = !m_write; e_wr = m_write; m_age = 1;
      end else if (bav && req_valid != 0) begin
        idx = m_ptr;
        while (!req_valid[idx]) idx = (idx + 1) % N;
        m_active = 1; m_age = 0; m_owner = idx; m_write = req_write[idx];
        e_ready = N'(1) << idx; e_addr = req_addr[idx]; e_wdata = req_wdata[idx];
      end
    end else begin
      done = m_write ? wd : dv;
      if (m_write ? dv : wd) e_err_un = 1;
      if (done || m_age == TO) begin
        e_rsp_valid = N'(1) << m_owner;
        e_rsp_err = !done;
        if (!done) e_err_to = 1;
        if (done && !m_write) e_rsp_data = rdata;
        m_ptr = (m_owner + 1) % N;
        m_active = 0;
      end else m_age++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) m_reset();
    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rsp_valid);
    chk("rsp_err", rsp_err, e_rsp_err);
    chk("rsp_data", rsp_data, e_rsp_data);
    chk("mem_address", mem_address, e_addr);
    chk("mem_write_data", mem_write_data, e_wdata);
    chk("mem_rd_req", rd, e_rd);
    chk("mem_wr_req", wr, e_wr);
    chk("busy", busy, m_active);
    chk("err_timeout", err_to, e_err_to);
    chk("err_unsolicited", err_un, e_err_un);
    if (!rst) m_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic wait_ready(input string name, input logic [N-1:0] exp);
    for (int i = 0; i < 30 && req_ready == 0; i++) tick();
    chk(name, req_ready, exp);
  endtask

  initial begin
    int cnt, pend;
    bit pwr;
    tick(); tick();
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mem_addr", mem_address, 0);
    chk("reset_err_un", err_un, 0);
    rst = 0;
    // single read, memory answers five cycles after the request
    bav = 1; req_addr[1] = 32'h100; req_valid[1] = 1;
    wait_ready("rd_ready", 4'b0010); req_valid[1] = 0;
    tick();
    chk("rd_mem_req", rd, 1);
    chk("rd_mem_addr", mem_address, 32'h100);
    chk("rd_no_wr", wr, 0);
    repeat (5) tick();
    chk("rd_no_early_rsp", rsp_valid, 0);
    dv = 1; rdata = {64{8'hA5}};
    tick(); dv = 0;
    chk("rd_rsp_valid", rsp_valid, 4'b0010);
    chk("rd_rsp_data", rsp_data, {64{8'hA5}});
    chk("rd_rsp_err", rsp_err, 0);
    // round robin between requesters 0 and 2 from reset
    do_reset(); req_valid = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_ready("rr_grant", (g % 2) ? 4'b0100 : 4'b0001);
      tick(); tick(); dv = 1; rdata = 512'(g);
      tick(); dv = 0;
      chk("rr_rsp_data", rsp_data, 512'(g));
    end
    req_valid = '0;
    // write, acknowledged three cycles after the request
    req_addr[3] = 32'h3000; req_wdata[3] = {16{32'hDEADBEEF}}; req_write[3] = 1; req_valid[3] = 1;
    wait_ready("wr_ready", 4'b1000); req_valid[3] = 0;
    tick();
    chk("wr_mem_req", wr, 1);
    chk("wr_no_rd", rd, 0);
    chk("wr_mem_data", mem_write_data, {16{32'hDEADBEEF}});
    tick();
    chk("wr_req_one_cycle", wr, 0);
    tick(); tick(); wd = 1;
    chk("wr_no_early_rsp", rsp_valid, 0);
    tick(); wd = 0; req_write[3] = 0;
    chk("wr_rsp_valid", rsp_valid, 4'b1000);
    chk("wr_rsp_data_kept", rsp_data, 512'd3);
    chk("wr_rsp_err", rsp_err, 0);
    // timeout on a read nobody answers
    req_addr[2] = 32'h200; req_valid[2] = 1;
    wait_ready("to_ready", 4'b0100); req_valid[2] = 0;
    tick();
    cnt = 0;
    repeat (15) begin tick(); if (rsp_valid != 0) cnt++; end
    chk("to_no_early_rsp", cnt, 0);
    tick();
    chk("to_rsp_valid", rsp_valid, 4'b0100);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_err_timeout", err_to, 1);
    chk("to_rsp_data_kept", rsp_data, 512'd3);
    req_addr[0] = 32'h40; req_valid[0] = 1;
    wait_ready("after_to_ready", 4'b0001); req_valid[0] = 0;
    tick(); tick(); dv = 1; rdata = 512'h1234;
    tick(); dv = 0;
    chk("after_to_rsp_valid", rsp_valid, 4'b0001);
    chk("after_to_rsp_err", rsp_err, 0);
    chk("after_to_rsp_data", rsp_data, 512'h1234);
    // buffer gating and a stray response
    bav = 0; req_valid[0] = 1; cnt = 0;
    repeat (10) begin tick(); if (req_ready != 0) cnt++; end
    chk("gate_no_ready", cnt, 0);
    bav = 1; tick();
    chk("gate_grant_next", req_ready, 4'b0001); req_valid[0] = 0;
    tick(); tick(); dv = 1; tick(); dv = 0;
    chk("gate_rsp_valid", rsp_valid, 4'b0001);
    chk("no_unsolicited_yet", err_un, 0);
    tick(); dv = 1; tick(); dv = 0;
    chk("stray_err_un", err_un, 1);
    chk("stray_no_rsp", rsp_valid, 0);
    // reset while waiting for a response
    req_addr[1] = 32'h500; req_valid[1] = 1;
    wait_ready("mid_ready", 4'b0010); req_valid[1] = 0;
    tick(); tick();
    rst = 1; #1;
    chk("mid_busy", busy, 0);
    chk("mid_mem_addr", mem_address, 0);
    chk("mid_err_to", err_to, 0);
    chk("mid_err_un", err_un, 0);
    chk("mid_rsp_data", rsp_data, 0);
    tick(); rst = 0;
    tick(); dv = 1; tick(); dv = 0;
    chk("late_err_un", err_un, 1);
    chk("late_no_rsp", rsp_valid, 0);
    // randomized traffic
    pend = -1; pwr = 0;
    repeat (3000) begin
      tick();
      dv = 0; wd = 0;
      if (e_rd || e_wr) begin
        pwr = e_wr;
        case ($urandom_range(0, 7))
          0: pend = 100;
          1: pend = TO - 1;
          default: pend = $urandom_range(1, 5);
        endcase
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if ($urandom_range(0, 7) == 0) begin
            if (pwr) dv = 1; else wd = 1;
          end else begin
            if (pwr) wd = 1; else dv = 1;
          end
        end
      end
      if ($urandom_range(0, 59) == 0) dv = 1;
      if ($urandom_range(0, 99) == 0) wd = 1;
      rdata = r512();
      bav = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (e_ready[i] || $urandom_range(0, 49) == 0) req_valid[i] = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i] = 1; req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i] = $urandom; req_wdata[i] = r512();
        end
      end
    end
    dv = 0; wd = 0; req_valid = '0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
